// File: rtl/mips_sched_pkg.sv
// rtl/mips_sched_pkg.sv - unit codes, default latencies and writeback slot type
package mips_sched_pkg;

  localparam logic [1:0] UNIT_AM  = 2'b00;
  localparam logic [1:0] UNIT_MEM = 2'b01;
  localparam logic [1:0] UNIT_MUL = 2'b10;
  localparam logic [1:0] UNIT_NOP = 2'b11;

  localparam int AM_LAT_DEF  = 4;
  localparam int MEM_LAT_DEF = 3;
  localparam int MUL_LAT_DEF = 6;
  localparam int MAX_LAT_DEF = 6;

  typedef struct packed {
    logic       valid;
    logic       writereg;
    logic [4:0] dest;
  } slot_t;

  // True when the slot writes register r in the current cycle (write-through forwarding).
  function automatic logic writes_now(input slot_t s, input logic [4:0] r);
    return s.valid & s.writereg & (s.dest == r);
  endfunction

endpackage

// File: rtl/wb_slot_ring.sv
// rtl/wb_slot_ring.sv - writeback reservation shift register, slot k writes k cycles from now
module wb_slot_ring
  import mips_sched_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int IDX_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  slot_t            load_entry,
  output logic [MAX_LAT:0] slot_valid,
  output slot_t            slot0
);

  slot_t slot_q [MAX_LAT+1];
  slot_t slot_d [MAX_LAT+1];

  // Shift one slot toward writeback, clear the top, then drop in the new reservation.
  always_comb begin
    for (int k = 0; k < MAX_LAT; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[MAX_LAT] = '0;
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (load_en && (load_idx == IDX_W'(k))) begin
        slot_d[k] = load_entry;
      end
    end
  end

  // Ring register; reset drops every reservation.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= MAX_LAT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= MAX_LAT; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Per-slot valid flags for the structural check and busy indication.
  always_comb begin
    for (int k = 0; k <= MAX_LAT; k++) begin
      slot_valid[k] = slot_q[k].valid;
    end
  end

  assign slot0 = slot_q[0];

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue-stage RAW/WAW/writeback hazard scheduler for AM, MEM and MUL
module issue_scoreboard
  import mips_sched_pkg::*;
#(
  parameter int AM_LAT  = AM_LAT_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_sb_valid,
  input  logic [1:0]  id_sb_unit,
  input  logic [4:0]  id_sb_addra,
  input  logic        id_sb_usea,
  input  logic [4:0]  id_sb_addrb,
  input  logic        id_sb_useb,
  input  logic [4:0]  id_sb_regdest,
  input  logic        id_sb_writereg,
  output logic        sb_iss_stall,
  output logic        sb_am_oper,
  output logic        sb_mem_oper,
  output logic        sb_mul_oper,
  output logic [31:0] sb_pending,
  output logic        sb_busy
);

  localparam int IDX_W = $clog2(MAX_LAT + 1);

  logic [31:0]      pending_q;
  logic [31:0]      pending_d;
  logic [MAX_LAT:0] slot_valid;
  slot_t            slot0;
  slot_t            load_entry;
  logic [IDX_W-1:0] lat;
  logic [IDX_W-1:0] load_idx;
  logic             is_op;
  logic             raw_a;
  logic             raw_b;
  logic             waw;
  logic             wb_busy;
  logic             hazard;
  logic             grant;
  logic             reserve;

  wb_slot_ring #(
    .MAX_LAT (MAX_LAT),
    .IDX_W   (IDX_W)
  ) u_ring (
    .clock      (clock),
    .reset      (reset),
    .load_en    (reserve),
    .load_idx   (load_idx),
    .load_entry (load_entry),
    .slot_valid (slot_valid),
    .slot0      (slot0)
  );

  // Zero-cycle issue decision: latency select, hazard tests, grant and per-unit strobes.
  always_comb begin
    is_op = id_sb_valid & (id_sb_unit != UNIT_NOP);
    case (id_sb_unit)
      UNIT_MEM: lat = IDX_W'(MEM_LAT);
      UNIT_MUL: lat = IDX_W'(MUL_LAT);
      default:  lat = IDX_W'(AM_LAT);
    endcase
    load_idx = lat - IDX_W'(1);
    raw_a    = id_sb_usea & pending_q[id_sb_addra] & ~writes_now(slot0, id_sb_addra);
    raw_b    = id_sb_useb & pending_q[id_sb_addrb] & ~writes_now(slot0, id_sb_addrb);
    waw      = id_sb_writereg & pending_q[id_sb_regdest] & ~writes_now(slot0, id_sb_regdest);
    wb_busy  = slot_valid[lat];
    hazard   = is_op & (raw_a | raw_b | waw | wb_busy);
    grant    = id_sb_valid & ~hazard & ~reset;
    reserve  = grant & is_op;
    sb_iss_stall = id_sb_valid & hazard & ~reset;
    sb_am_oper   = grant & (id_sb_unit == UNIT_AM);
    sb_mem_oper  = grant & (id_sb_unit == UNIT_MEM);
    sb_mul_oper  = grant & (id_sb_unit == UNIT_MUL);
    load_entry.valid    = 1'b1;
    load_entry.writereg = id_sb_writereg;
    load_entry.dest     = id_sb_regdest;
  end

  // Pending bitmap: retire the register written this cycle, then mark the new destination.
  always_comb begin
    pending_d = pending_q;
    if (slot0.valid && slot0.writereg && (slot0.dest != 5'd0)) begin
      pending_d[slot0.dest] = 1'b0;
    end
    if (reserve && id_sb_writereg && (id_sb_regdest != 5'd0)) begin
      pending_d[id_sb_regdest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending bitmap register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign sb_pending = pending_q;
  assign sb_busy    = |slot_valid;

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage hazard scheduler for the multi-unit back end: it decides each cycle whether the instruction presented by Decode may be dispatched to AluMisc, Mem or Mult. It tracks pending register writes (RAW/WAW) and reserves the single Writeback port cycle by cycle (structural hazard). It drives the issue stall and the per-unit `oper` strobes that fan out to the three functional units.

## Interface

- `AM_LAT`, 4: AluMisc grant-to-register-write latency in cycles.
- `MEM_LAT`, 3: Mem latency.
- `MUL_LAT`, 6: Mult latency.
- `MAX_LAT`, 6: ring depth. Must be ≥ every `*_LAT`; each `*_LAT` must be ≥ 1.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_sb_valid` in 1: Decode presents an instruction.
- `id_sb_unit` in 2: unit code: 00 AM, 01 MEM, 10 MUL, 11 NOP.
- `id_sb_addra` in 5: source A register number.
- `id_sb_usea` in 1: source A is read.
- `id_sb_addrb` in 5: source B register number.
- `id_sb_useb` in 1: source B is read.
- `id_sb_regdest` in 5: destination register number.
- `id_sb_writereg` in 1: instruction writes `regdest`.
- `sb_iss_stall` out 1: hold Decode/Fetch this cycle.
- `sb_am_oper` out 1: dispatch to AluMisc this cycle.
- `sb_mem_oper` out 1: dispatch to Mem this cycle.
- `sb_mul_oper` out 1: dispatch to Mult this cycle.
- `sb_pending` out 32: pending-write bitmap, debug/visibility.
- `sb_busy` out 1: any ring slot is valid.

## Operation

- State:
  - `pending[31:0]`; bit 0 is hardwired 0.
  - Ring `slot[0..MAX_LAT]`, each entry `{valid, writereg, dest}`. `slot[k]` = the instruction that writes the register file k cycles from now.
- Latency L is selected by unit. A grant in cycle t writes in cycle t+L.
- `wt(r)`: `slot[0].valid & slot[0].writereg & slot[0].dest==r`. The register file is write-through, so an operand written in the current cycle counts as ready.
- Hazards, evaluated combinationally when `id_sb_valid` is high and the unit is not NOP:
  - RAW: `usea & pending[addra] & !wt(addra)`, or the same test on B.
  - WAW: `writereg & pending[regdest] & !wt(regdest)`.
  - Structural: `slot[L].valid`. A slot is reserved even when `writereg`=0 (stores still consume a Writeback cycle).
- Grant = valid & no hazard & !reset.
  - On grant, exactly one `*_oper` is high and stall is low.
  - On hazard, stall is high and all `oper` strobes are low.
- NOP (11) is granted immediately: no `oper` strobe, no reservation, no pending change.
- Edge update:
  - Shift `slot[k] <= slot[k+1]`; the top slot is cleared.
  - On grant, load `slot[L-1]` with `{1, writereg, regdest}`.
  - If `slot[0]` writes r ≠ 0, clear `pending[r]`.
  - On grant with `writereg` and `regdest` ≠ 0, set `pending[regdest]`. Set wins over a simultaneous clear of the same register.
- Destination r0 never sets pending and never causes a WAW stall.

## Timing

- `stall` and the `oper` strobes are combinational from current state and `id_sb_*` (zero-cycle decision). `sb_pending` and `sb_busy` are registered.
- Reset values: `pending`=0, all slots invalid, `sb_busy`=0.
- During a reset cycle, `sb_iss_stall`=0 and all `oper` strobes=0 regardless of inputs.
- Reset asserted mid-operation drops all reservations. Units already in flight are reset by the same signal.
- Stall holds for as long as the hazard persists. Decode must hold `id_sb_*` stable while stalled.
- Dependent-operand wait: the consumer issues in the producer's write cycle t+L, i.e. L−1 stall cycles for a back-to-back dependency.

## Structure

- Package `mips_sched_pkg`:
  - Unit code constants (`UNIT_AM`, `UNIT_MEM`, `UNIT_MUL`, `UNIT_NOP`).
  - Default latencies.
  - Slot typedef `{valid, writereg, dest[4:0]}`.
- Sub-module `wb_slot_ring`: the reservation shift register.
  - Inputs: load index, load entry, load enable.
  - Outputs: per-slot valid and the `slot[0]` entry.
- The top level holds the `pending` bitmap and the hazard/grant logic.

## Test plan

- Independent AM ops to r1, r2, r3 in consecutive cycles → three grants, `sb_am_oper`=1 each cycle, no stall; `pending` bits clear in cycles t+4, t+5, t+6.
- MUL r5 granted at t; AM reading r5 presented at t+1 → stall t+1..t+5 (5 cycles), `sb_am_oper`=1 at t+6.
- MUL r7 granted at t; independent AM presented at t+2 (writes t+6, collides) → stall 1 cycle, granted t+3.
- AM with `regdest`=0, `writereg`=1 → `sb_pending` stays 0; a following reader of r0 is never stalled.
- MUL r9 at t; reset at t+2 → `sb_pending`=0, `sb_busy`=0 at t+3; reader of r9 granted at t+3.
- NOP presented while a MUL is in flight → granted, all `oper`=0, ring and `pending` unchanged.
